field_builder: RTL and testbench

Parametrised, sequential field generator for the snake game: on each `step` it rebuilds the cell map from the snake coordinate list, detects wall, self and block collisions, detects apple consumption, and places a new apple with an LFSR-seeded scan. It sits between snake movement logic and the screen and apple consumers. Unlike its predecessor, it processes one segment per cycle, tracks the empty-cell count exactly, supports static block cells, and reports a full field.

---
 rtl/field_pkg.sv | 10 +
 rtl/field_builder_if.sv | 33 +++
 rtl/field_builder_lfsr16.sv | 14 +
 rtl/field_builder.sv | 146 ++++++++++++++
 tb/tb_field_builder.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/field_pkg.sv
// field_pkg: cell codes, FSM states and LFSR taps shared by the snake field builder.
package field_pkg;
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_SNAKE = 2'b01;
    localparam logic [1:0] CELL_APPLE = 2'b10;
    localparam logic [1:0] CELL_BLOCK = 2'b11;
    typedef enum logic [2:0] {IDLE, CLEAR, DRAW, APPLE, FIN} state_t;
    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR sit at bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
endpackage

// File: rtl/field_builder_if.sv
// field_builder_if: request/result bundle between snake logic and the field builder.
interface field_builder_if #(
    parameter int SIZE_X = 10,
    parameter int SIZE_Y = 10,
    parameter int COORD_W = 8,
    parameter int MAX_LEN = SIZE_X * SIZE_Y
);
    localparam int N = SIZE_X * SIZE_Y;
    logic step;
    logic grow;
    logic [15:0] lengh;
    logic [2*COORD_W*MAX_LEN-1:0] snake_xy;
    logic block_we;
    logic [COORD_W-1:0] block_x;
    logic [COORD_W-1:0] block_y;
    logic [2*N-1:0] field;
    logic [15:0] empty_cells;
    logic [COORD_W-1:0] apple_x;
    logic [COORD_W-1:0] apple_y;
    logic busy;
    logic done;
    logic collision;
    logic ate;
    logic field_full;
    modport master (
        output step, grow, lengh, snake_xy, block_we, block_x, block_y,
        input field, empty_cells, apple_x, apple_y, busy, done, collision, ate, field_full
    );
    modport slave (
        input step, grow, lengh, snake_xy, block_we, block_x, block_y,
        output field, empty_cells, apple_x, apple_y, busy, done, collision, ate, field_full
    );
endinterface

// File: rtl/field_builder_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR used to seed the apple scan.
module lfsr16
    import field_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] out
);
    always_ff @(posedge clk)
        if (rst) out <= SEED;
        else out <= {^(out & LFSR_TAPS), out[15:1]};
endmodule

// File: rtl/field_builder.sv
// field_builder: rebuilds the snake cell map one segment per cycle, flags collisions,
// tracks apple consumption and places a new apple via an LFSR-seeded wrapping scan.
module field_builder
    import field_pkg::*;
#(
    parameter int SIZE_X = 10,
    parameter int SIZE_Y = 10,
    parameter int COORD_W = 8,
    parameter int MAX_LEN = SIZE_X * SIZE_Y,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input logic clk,
    input logic rst,
    field_builder_if.slave bus
);
    localparam int N = SIZE_X * SIZE_Y;
    localparam int IW = $clog2(N);
    state_t state, state_next;
    logic [15:0] lfsr, len_l, idx, empty_cells, blocks;
    logic [2*N-1:0] field;
    logic [COORD_W-1:0] apple_x, apple_y;
    logic [IW-1:0] pos, cnt, seg_c, blk_c, start;
    logic [31:0] sx, sy, bx, by;
    logic [1:0] seg_cell, blk_cell, pos_cell;
    logic seg_in, blk_ok, eat, found, last, want_apple, place, apple_pres, grow_l;
    logic busy, done, collision, ate, field_full;

    lfsr16 #(.SEED(SEED)) u_lfsr (.clk(clk), .rst(rst), .out(lfsr));

    assign sx = 32'(bus.snake_xy[2*COORD_W*idx +: COORD_W]);
    assign sy = 32'(bus.snake_xy[2*COORD_W*idx + COORD_W +: COORD_W]);
    assign seg_in = sx < SIZE_X && sy < SIZE_Y;
    assign seg_c = IW'(sy * SIZE_X + sx);
    assign seg_cell = field[2*seg_c +: 2];
    assign bx = 32'(bus.block_x);
    assign by = 32'(bus.block_y);
    assign blk_c = IW'(by * SIZE_X + bx);
    assign blk_cell = field[2*blk_c +: 2];
    assign blk_ok = state == IDLE && bus.block_we && bx < SIZE_X && by < SIZE_Y && blk_cell == CELL_EMPTY;
    assign pos_cell = field[2*pos +: 2];
    assign found = pos_cell == CELL_EMPTY;
    assign place = state == APPLE && found;
    assign eat = state == DRAW && seg_in && seg_cell == CELL_APPLE;
    assign last = idx == len_l - 1'b1;
    // An apple eaten by the final segment must still trigger placement.
    assign want_apple = !(apple_pres && !eat) || grow_l;
    assign start = IW'((32'(lfsr) * N) >> 16);

    always_ff @(posedge clk) state <= rst ? IDLE : state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = bus.step ? CLEAR : IDLE;
            CLEAR:   state_next = len_l != '0 ? DRAW : want_apple ? APPLE : FIN;
            DRAW:    state_next = !last ? DRAW : want_apple ? APPLE : FIN;
            APPLE:   state_next = found || cnt == IW'(N - 1) ? FIN : APPLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            field <= {{(2*N-2){1'b0}}, CELL_APPLE};
            empty_cells <= 16'(N - 1);
            apple_x <= '0;
            apple_y <= '0;
            apple_pres <= 1'b1;
            blocks <= '0;
            grow_l <= 1'b0;
            collision <= 1'b0;
            ate <= 1'b0;
            field_full <= 1'b0;
            len_l <= '0;
            idx <= '0;
            pos <= '0;
            cnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= state_next != IDLE;
            done <= state_next == FIN;
            grow_l <= (grow_l && !place) || bus.grow;
            case (state)
                IDLE: begin
                    if (blk_ok) begin
                        field[2*blk_c +: 2] <= CELL_BLOCK;
                        blocks <= blocks + 1'b1;
                        empty_cells <= empty_cells - 1'b1;
                    end
                    if (bus.step) begin
                        collision <= 1'b0;
                        ate <= 1'b0;
                        field_full <= 1'b0;
                        len_l <= bus.lengh > 16'(MAX_LEN) ? 16'(MAX_LEN) : bus.lengh;
                        idx <= '0;
                    end
                end
                CLEAR: begin
                    for (int i = 0; i < N; i++)
                        if (field[2*i +: 2] == CELL_SNAKE) field[2*i +: 2] <= CELL_EMPTY;
                    empty_cells <= 16'(N) - blocks - 16'(apple_pres);
                end
                DRAW: begin
                    idx <= idx + 1'b1;
                    if (!seg_in || seg_cell == CELL_BLOCK || seg_cell == CELL_SNAKE) collision <= 1'b1;
                    else begin
                        field[2*seg_c +: 2] <= CELL_SNAKE;
                        if (eat) begin
                            ate <= 1'b1;
                            apple_pres <= 1'b0;
                        end else empty_cells <= empty_cells - 1'b1;
                    end
                end
                APPLE: begin
                    if (found) begin
                        field[2*pos +: 2] <= CELL_APPLE;
                        apple_x <= COORD_W'(32'(pos) % SIZE_X);
                        apple_y <= COORD_W'(32'(pos) / SIZE_X);
                        empty_cells <= empty_cells - 1'b1;
                        apple_pres <= 1'b1;
                    end else begin
                        pos <= pos == IW'(N - 1) ? '0 : pos + 1'b1;
                        cnt <= cnt + 1'b1;
                        if (cnt == IW'(N - 1)) field_full <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (state_next == APPLE && state != APPLE) begin
                pos <= start;
                cnt <= '0;
            end
        end
    end

    assign bus.field = field;
    assign bus.empty_cells = empty_cells;
    assign bus.apple_x = apple_x;
    assign bus.apple_y = apple_y;
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.collision = collision;
    assign bus.ate = ate;
    assign bus.field_full = field_full;
endmodule

// File: tb/tb_field_builder.sv
// tb_field_builder: directed vectors and hand-written corner sequences for field_builder on a 10x10 field.
module tb_field_builder;
    import field_pkg::*;
    localparam int SX = 10, SY = 10, CW = 8, ML = 100, N = 100;

    typedef struct {
        int len;
        int x0, y0, x1, y1, x2, y2;
        int lat;
        int coll;
        int empty;
    } vec_t;

    logic clk = 0;
    logic rst = 1;
    logic [15:0] m_lfsr;
    logic [1:0] exp_f [N];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    field_builder_if #(.SIZE_X(SX), .SIZE_Y(SY), .COORD_W(CW), .MAX_LEN(ML)) bus ();

    field_builder #(.SIZE_X(SX), .SIZE_Y(SY), .COORD_W(CW), .MAX_LEN(ML), .SEED(16'hACE1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference LFSR: taps 16,14,13,11 shifting right, one step per clock.
    always @(posedge clk)
        m_lfsr <= rst ? 16'hACE1 : {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic check_field(input string name);
        int nd = 0;
        int first = 0;
        for (int i = N - 1; i >= 0; i--)
            if (bus.field[2*i +: 2] != exp_f[i]) begin
                nd++;
                first = i;
            end
        total++;
        if (nd != 0) begin
            bad++;
            $display("FAIL %s: %0d cells differ, cell %0d got %0d want %0d",
                     name, nd, first, bus.field[2*first +: 2], exp_f[first]);
        end
    endtask

    task automatic reset_field();
        for (int i = 0; i < N; i++) exp_f[i] = CELL_EMPTY;
        exp_f[0] = CELL_APPLE;
    endtask

    task automatic clear_segs();
        bus.snake_xy = '0;
    endtask

    task automatic set_seg(input int i, input int x, input int y);
        bus.snake_xy[16*i +: 8] = 8'(x);
        bus.snake_xy[16*i + 8 +: 8] = 8'(y);
    endtask

    task automatic check_reset(input string tag);
        reset_field();
        check_field({tag, "_field"});
        check({tag, "_empty"}, int'(bus.empty_cells), 99);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_coll"}, int'(bus.collision), 0);
        check({tag, "_ate"}, int'(bus.ate), 0);
        check({tag, "_full"}, int'(bus.field_full), 0);
        check({tag, "_apple_x"}, int'(bus.apple_x), 0);
        check({tag, "_apple_y"}, int'(bus.apple_y), 0);
    endtask

    task automatic write_block(input int x, input int y);
        @(negedge clk);
        bus.block_we = 1;
        bus.block_x = 8'(x);
        bus.block_y = 8'(y);
        @(posedge clk);
        #1 bus.block_we = 0;
    endtask

    // Pulses step (optionally with a block write in the same cycle) and counts cycles to done.
    task automatic run_step(input int len, input bit bw, input int bxx, input int byy,
                            output int lat, output logic [15:0] cap);
        @(negedge clk);
        bus.lengh = 16'(len);
        bus.step = 1;
        bus.block_we = bw;
        bus.block_x = 8'(bxx);
        bus.block_y = 8'(byy);
        @(posedge clk);
        #1;
        bus.step = 0;
        bus.block_we = 0;
        lat = 0;
        cap = '0;
        while (lat < 300) begin
            @(negedge clk);
            lat++;
            if (lat == len + 1) cap = m_lfsr;
            if (bus.done) break;
        end
        if (!bus.done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done want done within 300 cycles");
        end
    endtask

    initial begin
        vec_t vt[6];
        int xs[3];
        int ys[3];
        int lat;
        logic [15:0] cap;
        int s, a, k;

        vt[0] = '{3, 5, 5, 4, 5, 3, 5, 5, 0, 96};
        vt[1] = '{1, 10, 3, 0, 0, 0, 0, 3, 1, 99};
        vt[2] = '{2, 2, 2, 2, 2, 0, 0, 4, 1, 98};
        vt[3] = '{2, 9, 9, 0, 9, 0, 0, 4, 0, 97};
        vt[4] = '{2, 1, 0, 3, 10, 0, 0, 4, 1, 98};
        vt[5] = '{0, 0, 0, 0, 0, 0, 0, 2, 0, 99};

        bus.step = 0;
        bus.grow = 0;
        bus.lengh = 0;
        bus.snake_xy = '0;
        bus.block_we = 0;
        bus.block_x = 0;
        bus.block_y = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        check_reset("reset");

        for (int v = 0; v < 6; v++) begin
            xs = '{vt[v].x0, vt[v].x1, vt[v].x2};
            ys = '{vt[v].y0, vt[v].y1, vt[v].y2};
            clear_segs();
            reset_field();
            for (int i = 0; i < vt[v].len; i++) begin
                set_seg(i, xs[i], ys[i]);
                if (xs[i] < SX && ys[i] < SY) exp_f[ys[i]*SX + xs[i]] = CELL_SNAKE;
            end
            run_step(vt[v].len, 0, 0, 0, lat, cap);
            check($sformatf("v%0d_latency", v), lat, vt[v].lat);
            check($sformatf("v%0d_collision", v), int'(bus.collision), vt[v].coll);
            check($sformatf("v%0d_ate", v), int'(bus.ate), 0);
            check($sformatf("v%0d_empty", v), int'(bus.empty_cells), vt[v].empty);
            check($sformatf("v%0d_full", v), int'(bus.field_full), 0);
            check_field($sformatf("v%0d_field", v));
        end

        reset_field();
        write_block(7, 7);
        exp_f[77] = CELL_BLOCK;
        @(negedge clk);
        check("blk_empty", int'(bus.empty_cells), 98);
        check_field("blk_field");
        write_block(10, 0);
        write_block(0, 0);
        @(negedge clk);
        check("blk_ignored_empty", int'(bus.empty_cells), 98);
        check_field("blk_ignored_field");

        clear_segs();
        set_seg(0, 8, 8);
        exp_f[88] = CELL_BLOCK;
        run_step(1, 1, 8, 8, lat, cap);
        check("blkstep_latency", lat, 3);
        check("blkstep_collision", int'(bus.collision), 1);
        check("blkstep_empty", int'(bus.empty_cells), 97);
        check_field("blkstep_field");

        clear_segs();
        set_seg(0, 0, 0);
        exp_f[0] = CELL_SNAKE;
        run_step(1, 0, 0, 0, lat, cap);
        s = (int'(cap) * N) >> 16;
        a = -1;
        k = 0;
        for (int j = 0; j < N; j++)
            if (a < 0 && exp_f[(s + j) % N] == CELL_EMPTY) begin
                a = (s + j) % N;
                k = j + 1;
            end
        exp_f[a] = CELL_APPLE;
        check("eat_latency", lat, 3 + k);
        check("eat_ate", int'(bus.ate), 1);
        check("eat_collision", int'(bus.collision), 0);
        check("eat_empty", int'(bus.empty_cells), 96);
        check("eat_apple_x", int'(bus.apple_x), a % SX);
        check("eat_apple_y", int'(bus.apple_y), a / SX);
        check_field("eat_field");

        @(negedge clk);
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        check_reset("rereset");

        for (int c = 1; c < N; c++) write_block(c % SX, c / SX);
        @(negedge clk);
        check("fill_empty", int'(bus.empty_cells), 0);
        clear_segs();
        set_seg(0, 0, 0);
        run_step(1, 0, 0, 0, lat, cap);
        for (int i = 0; i < N; i++) exp_f[i] = CELL_BLOCK;
        exp_f[0] = CELL_SNAKE;
        check("full_latency", lat, 103);
        check("full_flag", int'(bus.field_full), 1);
        check("full_ate", int'(bus.ate), 1);
        check("full_empty", int'(bus.empty_cells), 0);
        check_field("full_field");

        clear_segs();
        for (int i = 0; i < 5; i++) set_seg(i, i, 3);
        @(negedge clk);
        bus.lengh = 5;
        bus.step = 1;
        @(posedge clk);
        #1 bus.step = 0;
        repeat (3) @(negedge clk);
        check("middraw_busy", int'(bus.busy), 1);
        rst = 1;
        @(posedge clk);
        #1;
        check_reset("midreset");
        @(negedge clk);
        rst = 0;

        clear_segs();
        set_seg(0, 5, 5);
        run_step(1, 0, 0, 0, lat, cap);
        check("after_latency", lat, 3);
        check("after_empty", int'(bus.empty_cells), 98);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
